// File: rtl/seg_scan_if.sv
// Bus-side port group of seg_scan_ctrl: load strobe, display value, pending flag.
interface seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  Load;
  logic [4*DIGITS-1:0]   Data;
  logic                  Pending;

  modport master (output Load, output Data, input Pending);
  modport slave  (input Load, input Data, output Pending);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Double-buffered, time-multiplexed common-anode seven-segment scan controller.
// Optional leading-zero blanking is enabled with `define LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000
) (
  input  logic              Clk,
  input  logic              Rst,
  seg_scan_if.slave         bus,
  output logic [6:0]        Seg,
  output logic [DIGITS-1:0] An,
  output logic              Frame
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;

  logic [PW-1:0]     p_q, p_d;
  logic [DW-1:0]     d_q, d_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic [VW-1:0]     display_q, display_d;
  logic              pending_q, pending_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_q, frame_d;

  logic              p_end, d_end, commit;
  logic [3:0]        nib;
  logic [6:0]        seg_dec;
  logic [DIGITS-1:0] blank;
  logic              blank_cur;

  // Scan position, double buffer and commit at the last slot of a frame.
  always_comb begin
    p_end     = (p_q == PW'(DIV - 1));
    d_end     = (d_q == DW'(DIGITS - 1));
    commit    = p_end && d_end && pending_q;
    p_d       = p_end ? '0 : p_q + PW'(1);
    d_d       = d_q;
    if (p_end) begin
      d_d = d_end ? '0 : d_q + DW'(1);
    end
    display_d = commit ? shadow_q : display_q;
    shadow_d  = bus.Load ? bus.Data : shadow_q;
    pending_d = pending_q;
    if (bus.Load) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_acc;

  // A digit is blank when it and every more-significant nibble are zero.
  always_comb begin
    zero_acc = 1'b1;
    blank    = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      zero_acc = zero_acc & (display_q[4*k +: 4] == 4'h0);
      if (k != 0) begin
        blank[k] = zero_acc;
      end
    end
  end
`else
  assign blank = '0;
`endif

  // Single shared decoder fed by the current digit's nibble.
  always_comb begin
    nib       = 4'h0;
    blank_cur = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (d_q == DW'(k)) begin
        nib       = display_q[4*k +: 4];
        blank_cur = blank[k];
      end
    end
    case (nib)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      default: seg_dec = 7'h0E;
    endcase
  end

  // Output drive; slot phase 0 is the all-off guard cycle.
  always_comb begin
    seg_d   = 7'h7F;
    an_d    = '1;
    frame_d = (p_q == '0) && (d_q == '0);
    if (p_q != '0) begin
      an_d  = ~(DIGITS'(1) << d_q);
      seg_d = blank_cur ? 7'h7F : seg_dec;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      p_q       <= '0;
      d_q       <= '0;
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      p_q       <= p_d;
      d_q       <= d_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.Pending = pending_q;
  assign Seg         = seg_q;
  assign An          = an_q;
  assign Frame       = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=4 (16-clock frame).
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 4;
  localparam int unsigned FRAME  = DIGITS * DIV;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [6:0]        Seg;
  logic [DIGITS-1:0] An;
  logic              Frame;

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .bus   (bus),
    .Seg   (Seg),
    .An    (An),
    .Frame (Frame)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int pos   = 0;  // bench's own view of the internal scan index after each edge

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < int'(FRAME); i++) begin
      if (pos == target) break;
      tick();
    end
    chk("run_until", 32'(pos), 32'(target));
  endtask

  // Checks one whole frame starting from scan index 0.
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] segs [4];
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int i = 0; i < int'(FRAME); i++) begin
      int slot, phase;
      slot  = i / int'(DIV);
      phase = i % int'(DIV);
      tick();
      chk({tag, "_frame"}, 32'(Frame), (i == 0) ? 32'd1 : 32'd0);
      chk({tag, "_an"}, 32'(An), (phase == 0) ? 32'hF : 32'(~(4'b0001 << slot) & 4'hF));
      chk({tag, "_seg"}, 32'(Seg), (phase == 0) ? 32'h7F : 32'(segs[slot]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst      = 1'b1;
    bus.Load = 1'b0;
    bus.Data = '0;
    tick();
    tick();
    chk("rst_seg", 32'(Seg), 32'h7F);
    chk("rst_an", 32'(An), 32'hF);
    chk("rst_frame", 32'(Frame), 32'd0);
    chk("rst_pending", 32'(bus.Pending), 32'd0);

    // Idle frame after reset shows zeros; next frame pulse on clock 17.
    Rst = 1'b0;
    pos = 0;
    check_frame("idle", 7'h40, 7'h40, 7'h40, 7'h40);
    tick();
    chk("frame17", 32'(Frame), 32'd1);

    // Mid-frame load, commit at end of frame.
    bus.Load = 1'b1; bus.Data = 16'h8881;
    tick();
    bus.Load = 1'b0;
    chk("load_pending", 32'(bus.Pending), 32'd1);
    run_until(15);
    chk("pending_hold", 32'(bus.Pending), 32'd1);
    tick();
    chk("pending_clr", 32'(bus.Pending), 32'd0);
    check_frame("v8881", 7'h79, 7'h00, 7'h00, 7'h00);

    // Last load wins.
    bus.Load = 1'b1; bus.Data = 16'h1111;
    tick();
    bus.Data = 16'h8888;
    tick();
    bus.Load = 1'b0;
    run_until(15);
    chk("lw_pending", 32'(bus.Pending), 32'd1);
    tick();
    chk("lw_clr", 32'(bus.Pending), 32'd0);
    check_frame("v8888", 7'h00, 7'h00, 7'h00, 7'h00);

    // Load on the commit cycle: display takes A, B follows a frame later.
    bus.Load = 1'b1; bus.Data = 16'h2222;
    tick();
    bus.Load = 1'b0;
    run_until(15);
    bus.Load = 1'b1; bus.Data = 16'h5555;
    tick();
    bus.Load = 1'b0;
    chk("cc_pending", 32'(bus.Pending), 32'd1);
    check_frame("vA", 7'h24, 7'h24, 7'h24, 7'h24);
    chk("cc_pending_clr", 32'(bus.Pending), 32'd0);
    check_frame("vB", 7'h12, 7'h12, 7'h12, 7'h12);

    // Reset while digit 2 is lit with a value pending.
    bus.Load = 1'b1; bus.Data = 16'h3333;
    tick();
    bus.Load = 1'b0;
    run_until(10);
    chk("d2_an", 32'(An), 32'hB);
    chk("d2_seg", 32'(Seg), 32'h12);
    Rst = 1'b1;
    tick();
    pos = 0;
    Rst = 1'b0;
    chk("mrst_an", 32'(An), 32'hF);
    chk("mrst_seg", 32'(Seg), 32'h7F);
    chk("mrst_pending", 32'(bus.Pending), 32'd0);
    check_frame("post_rst", 7'h40, 7'h40, 7'h40, 7'h40);
    chk("post_rst_pending", 32'(bus.Pending), 32'd0);

    // Leading zeros (blanked only when the feature is built in).
    bus.Load = 1'b1; bus.Data = 16'h0081;
    tick();
    bus.Load = 1'b0;
    run_until(15);
    tick();
    check_frame("v0081", 7'h79, 7'h00, LZ, LZ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
